evo_rst_seq: RTL

Parametrised reset sequencer and timebase generator, the next-generation clock/reset block for Evo designs. It filters an asynchronous PLL lock indication and releases several reset domains in a fixed, staggered order. It also supports software-requested partial resets of selected domains and generates single-cycle tick enables at programmable divisions of clk_in. It sits between the PLL/board reset and all downstream BSP logic.

---
 rtl/evo_rst_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/evo_rst_seq.sv
// Reset sequencer and timebase: filters PLL lock, releases reset domains in a
// staggered order, handles software partial resets and emits divided tick enables.

module evo_rst_tick #(
  parameter logic [15:0] DIV = 16'd12
) (
  input  logic clk_in,
  input  logic core_rstn,
  input  logic run,
  output logic tick
);
  localparam logic [15:0] LAST = DIV - 16'd1;

  logic [15:0] cnt;

  always_ff @(posedge clk_in or negedge core_rstn) begin
    if (!core_rstn) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 16'd1;
      tick <= 1'b0;
    end
  end
endmodule

module evo_rst_seq #(
  parameter int NUM_DOMAINS      = 4,
  parameter int STAGE_DELAY      = 16,
  parameter int LOCK_FILT_CYCLES = 48,
  parameter int NUM_TICKS        = 2,
  parameter logic [16*NUM_TICKS-1:0] TICK_DIV = 32'h2EE0_000C
) (
  input  logic                   clk_in,
  input  logic                   core_rstn,
  input  logic                   pll_locked,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] sw_rst_mask,
  output logic [NUM_DOMAINS-1:0] dom_rstn,
  output logic                   all_rdy,
  output logic                   lock_filt,
  output logic [7:0]             lock_lost_cnt,
  output logic [1:0]             state,
  output logic [NUM_TICKS-1:0]   tick
);
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    RUN       = 2'd2,
    SW_RESET  = 2'd3
  } state_t;

  localparam int          IW      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [15:0] STG_RLD = 16'(STAGE_DELAY - 1);
  localparam logic [7:0]  LF_END  = 8'(LOCK_FILT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOMAINS - 1);

  state_t      st;
  logic [1:0]  sync_pipe;
  logic [7:0]  lf_cnt;
  logic [15:0] stage_cnt;
  logic [IW-1:0] idx;
  logic        leave_run;
  logic        tick_run;

  assign state = st;

  // Lock filter: lock_filt only follows s2 after a sustained disagreement.
  always_ff @(posedge clk_in or negedge core_rstn) begin
    if (!core_rstn) begin
      sync_pipe <= '0;
      lf_cnt    <= '0;
      lock_filt <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], pll_locked};
      if (sync_pipe[1] == lock_filt) begin
        lf_cnt <= '0;
      end else if (lf_cnt == LF_END) begin
        lock_filt <= sync_pipe[1];
        lf_cnt    <= '0;
      end else begin
        lf_cnt <= lf_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge core_rstn) begin
    if (!core_rstn) begin
      st            <= WAIT_LOCK;
      dom_rstn      <= '0;
      all_rdy       <= 1'b0;
      lock_lost_cnt <= '0;
      stage_cnt     <= '0;
      idx           <= '0;
    end else if (st != WAIT_LOCK && !lock_filt) begin
      // lock loss outranks every other transition
      st       <= WAIT_LOCK;
      dom_rstn <= '0;
      all_rdy  <= 1'b0;
      if (lock_lost_cnt != 8'hFF) lock_lost_cnt <= lock_lost_cnt + 8'd1;
    end else begin
      case (st)
        WAIT_LOCK: begin
          dom_rstn <= '0;
          all_rdy  <= 1'b0;
          if (lock_filt) begin
            st        <= RELEASE;
            idx       <= '0;
            stage_cnt <= STG_RLD;
          end
        end
        RELEASE: begin
          if (stage_cnt == 16'd0) begin
            dom_rstn[idx] <= 1'b1;
            idx           <= idx + 1'b1;
            stage_cnt     <= STG_RLD;
            if (idx == IDX_LAST) begin
              st      <= RUN;
              all_rdy <= 1'b1;
            end
          end else begin
            stage_cnt <= stage_cnt - 16'd1;
          end
        end
        RUN: begin
          if (sw_rst_req && |sw_rst_mask) begin
            dom_rstn  <= dom_rstn & ~sw_rst_mask;
            stage_cnt <= STG_RLD;
            st        <= SW_RESET;
            all_rdy   <= 1'b0;
          end
        end
        SW_RESET: begin
          if (stage_cnt == 16'd0) begin
            // unmasked domains never dropped, so releasing all is equivalent
            dom_rstn <= '1;
            st       <= RUN;
            all_rdy  <= 1'b1;
          end else begin
            stage_cnt <= stage_cnt - 16'd1;
          end
        end
        default: st <= WAIT_LOCK;
      endcase
    end
  end

  // Ticks are suppressed on the edge that leaves RUN as well as outside it.
  assign leave_run = (st == RUN) && (!lock_filt || (sw_rst_req && |sw_rst_mask));
  assign tick_run  = (st == RUN) && !leave_run;

  for (genvar i = 0; i < NUM_TICKS; i++) begin : g_tick
    evo_rst_tick #(.DIV(TICK_DIV[16*i +: 16])) u_tick (
      .clk_in    (clk_in),
      .core_rstn (core_rstn),
      .run       (tick_run),
      .tick      (tick[i])
    );
  end
endmodule
